// File: rtl/bus_mon_tracer_pkg.sv
// Shared types for the bus monitor tracer: record layout, access kinds,
// serializer states and the record-to-byte mapping.
package bus_mon_tracer_pkg;

  localparam int unsigned RECORD_BYTES = 5;

  typedef enum logic [1:0] {
    KIND_DRAM_RD = 2'b00,
    KIND_DRAM_WR = 2'b01,
    KIND_NR_RD   = 2'b10,
    KIND_NR_WR   = 2'b11
  } kind_e;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_e;

  typedef struct packed {
    kind_e       kind;
    logic        bank;
    logic        ovf;
    logic [10:0] row;
    logic [10:0] col;
    logic [1:0]  lane;
    logic [7:0]  data;
  } trace_rec_t;

  function automatic logic [7:0] rec_byte(input trace_rec_t r, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {r.kind, r.bank, r.ovf, 1'b1, r.row[10:8]};
      3'd1:    b = r.row[7:0];
      3'd2:    b = r.col[7:0];
      3'd3:    b = {r.col[10:8], r.lane, 3'b000};
      3'd4:    b = r.data;
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bus_mon_fifo.sv
// Single-clock FIFO, show-ahead read, full/empty from the pointer MSBs.
// A write while full succeeds when a read happens in the same cycle.
module bus_mon_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd      = i_rd_en & ~o_empty;
  assign w_wr      = i_wr_en & (~o_full | w_rd);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/bus_mon_tracer.sv
// Turns bus monitor strobes into 5-byte trace records streamed over valid/ready.
// Optional row filter: define BUS_MON_TRACER_FILTER_EN.
module bus_mon_tracer
  import bus_mon_tracer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              trace_en,
  input  logic              bus_mon_n_ras_a,
  input  logic              bus_mon_n_ras_b,
  input  logic              bus_mon_n_cas_0,
  input  logic              bus_mon_n_cas_1,
  input  logic              bus_mon_n_nren,
  input  logic              bus_mon_n_we,
  input  logic              bus_mon_data_out_en,
  input  logic [ADDR_W-1:0] bus_mon_addr,
  input  logic [DATA_W-1:0] bus_mon_data_out,
  input  logic [ADDR_W-1:0] filter_match,
  input  logic [ADDR_W-1:0] filter_mask,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);

  logic              r_s_n_ras_a, r_s_n_ras_b, r_s_n_cas_0, r_s_n_cas_1, r_s_n_nren;
  logic              r_s_n_we, r_s_data_out_en;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_data;
  logic              r_p_row_act, r_p_n_cas_0, r_p_n_cas_1;
  logic [ADDR_W-1:0] r_row;
  logic              r_bank, r_kind_nr;
  trace_rec_t        r_rec, r_cur, w_evt_rec, w_wr_rec, w_rd_rec;
  logic              r_rec_valid, r_overflow;
  ser_state_e        r_state, w_state_nxt;
  logic [2:0]        r_idx, w_idx_nxt;
  logic              w_row_act, w_row_fall, w_cas_fall, w_col_evt, w_pass;
  logic              w_commit_try, w_push, w_drop, w_pop, w_full, w_empty;

  // Strobes reset to their inactive level so leaving reset creates no edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      {r_s_n_ras_a, r_s_n_ras_b, r_s_n_cas_0, r_s_n_cas_1, r_s_n_nren} <= '1;
      {r_p_n_cas_0, r_p_n_cas_1} <= '1;
      r_s_n_we        <= 1'b1;
      r_s_data_out_en <= 1'b0;
      r_s_addr        <= '0;
      r_s_data        <= '0;
      r_p_row_act     <= 1'b0;
    end else begin
      r_s_n_ras_a     <= bus_mon_n_ras_a;
      r_s_n_ras_b     <= bus_mon_n_ras_b;
      r_s_n_cas_0     <= bus_mon_n_cas_0;
      r_s_n_cas_1     <= bus_mon_n_cas_1;
      r_s_n_nren      <= bus_mon_n_nren;
      r_s_n_we        <= bus_mon_n_we;
      r_s_data_out_en <= bus_mon_data_out_en;
      r_s_addr        <= bus_mon_addr;
      r_s_data        <= bus_mon_data_out;
      r_p_row_act     <= w_row_act;
      r_p_n_cas_0     <= r_s_n_cas_0;
      r_p_n_cas_1     <= r_s_n_cas_1;
    end
  end

  assign w_row_act  = ~r_s_n_ras_a | ~r_s_n_ras_b | ~r_s_n_nren;
  assign w_row_fall = w_row_act & ~r_p_row_act;
  assign w_cas_fall = (r_p_n_cas_0 & ~r_s_n_cas_0) | (r_p_n_cas_1 & ~r_s_n_cas_1);
  assign w_col_evt  = w_cas_fall & w_row_act;

`ifdef BUS_MON_TRACER_FILTER_EN
  assign w_pass = ((r_row & filter_mask) == (filter_match & filter_mask));
`else
  logic w_unused_filter;
  assign w_unused_filter = ^{filter_match, filter_mask};
  assign w_pass          = 1'b1;
`endif

  always_comb begin
    w_evt_rec      = '0;
    w_evt_rec.kind = kind_e'({r_kind_nr, ~r_s_n_we});
    w_evt_rec.bank = r_bank;
    w_evt_rec.row  = r_row;
    w_evt_rec.col  = r_s_addr;
    w_evt_rec.lane = {~r_s_n_cas_1, ~r_s_n_cas_0};
    w_evt_rec.data = (r_s_data_out_en & ~r_s_n_we) ? r_s_data : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_row       <= '0;
      r_bank      <= 1'b0;
      r_kind_nr   <= 1'b0;
      r_rec_valid <= 1'b0;
      r_rec       <= '0;
    end else begin
      if (w_row_fall) begin
        r_row     <= r_s_addr;
        r_bank    <= ~r_s_n_ras_b;
        r_kind_nr <= ~r_s_n_nren;
      end
      r_rec_valid <= w_col_evt & w_pass;
      r_rec       <= w_evt_rec;
    end
  end

  // A pop in the commit cycle frees the slot the commit needs.
  assign w_commit_try = r_rec_valid & trace_en;
  assign w_push       = w_commit_try & (~w_full | w_pop);
  assign w_drop       = w_commit_try & w_full & ~w_pop;

  always_comb begin
    w_wr_rec     = r_rec;
    w_wr_rec.ovf = r_overflow;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      r_overflow <= 1'b0;
    else if (w_push) r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  bus_mon_fifo #(
    .WIDTH($bits(trace_rec_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_wr_en  (w_push),
    .i_wr_data(w_wr_rec),
    .i_rd_en  (w_pop),
    .o_rd_data(w_rd_rec),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = SER_SEND;
        end
      end
      SER_SEND: begin
        if (out_ready) begin
          if (r_idx == 3'(RECORD_BYTES - 1)) begin
            w_idx_nxt = '0;
            if (!w_empty) w_pop       = 1'b1;
            else          w_state_nxt = SER_IDLE;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      default: w_state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= SER_IDLE;
      r_idx   <= '0;
      r_cur   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_pop) r_cur <= w_rd_rec;
    end
  end

  assign out_valid = (r_state == SER_SEND);
  assign out_data  = out_valid ? rec_byte(r_cur, r_idx) : '0;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_bus_mon_tracer.sv
// Directed self-checking bench for bus_mon_tracer; build with
// BUS_MON_TRACER_FILTER_EN defined to exercise the row filter.
module tb_bus_mon_tracer;

  logic        clk;
  logic        n_rst;
  logic        trace_en;
  logic        n_ras_a, n_ras_b, n_cas_0, n_cas_1, n_nren, n_we, data_out_en;
  logic [10:0] addr;
  logic [7:0]  data_out;
  logic [10:0] filter_match, filter_mask;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] cap_q[$];

  bus_mon_tracer #(.ADDR_W(11), .DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .trace_en           (trace_en),
    .bus_mon_n_ras_a    (n_ras_a),
    .bus_mon_n_ras_b    (n_ras_b),
    .bus_mon_n_cas_0    (n_cas_0),
    .bus_mon_n_cas_1    (n_cas_1),
    .bus_mon_n_nren     (n_nren),
    .bus_mon_n_we       (n_we),
    .bus_mon_data_out_en(data_out_en),
    .bus_mon_addr       (addr),
    .bus_mon_data_out   (data_out),
    .filter_match       (filter_match),
    .filter_mask        (filter_mask),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .overflow           (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bytes accepted at the coming rising edge.
  always @(negedge clk) begin
    if (n_rst && out_valid && out_ready) cap_q.push_back(out_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (cap_q.size() < n && t < 600) begin
      tick(1);
      t++;
    end
  endtask

  task automatic bus_access(input bit nr, input bit bank_b, input logic [10:0] row,
                            input logic [1:0] lanes, input logic [10:0] col,
                            input bit wr, input bit den, input logic [7:0] data);
    addr = row;
    if (nr) n_nren = 1'b0;
    else if (bank_b) n_ras_b = 1'b0;
    else n_ras_a = 1'b0;
    tick(2);
    addr = col; n_we = ~wr; data_out_en = den; data_out = data;
    n_cas_0 = ~lanes[0]; n_cas_1 = ~lanes[1];
    tick(2);
    n_cas_0 = 1'b1; n_cas_1 = 1'b1;
    tick(1);
    n_ras_a = 1'b1; n_ras_b = 1'b1; n_nren = 1'b1; n_we = 1'b1; data_out_en = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h ovf=%b, required 0 00 0", out_valid, out_data, overflow);
    end
  endtask

  task automatic test_single_write();
    logic [7:0] exp [5] = '{8'h49, 8'h23, 8'h45, 8'h08, 8'hA5};
    cap_q.delete();
    addr = 11'h123; n_ras_a = 1'b0;
    tick(2);
    addr = 11'h045; n_we = 1'b0; data_out_en = 1'b1; data_out = 8'hA5; n_cas_0 = 1'b0;
    tick(1);
    tick(2);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b at N+2, required 0", out_valid);
    end
    tick(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h49) begin
      errors++;
      $display("FAIL latency: valid=%b data=%h at N+3, required 1 49", out_valid, out_data);
    end
    n_cas_0 = 1'b1;
    tick(1);
    n_ras_a = 1'b1; n_we = 1'b1; data_out_en = 1'b0;
    wait_bytes(5);
    tick(3);
    checks++;
    if (cap_q.size() != 5) begin
      errors++;
      $display("FAIL single_write_count: got %0d bytes, required 5", cap_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL single_write_b%0d: got %h, required %h", i, cap_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_page_mode();
    logic [7:0] exp [15] = '{8'h2F, 8'hFF, 8'h01, 8'h08, 8'h00,
                             8'h2F, 8'hFF, 8'h02, 8'h08, 8'h00,
                             8'h2F, 8'hFF, 8'h03, 8'h08, 8'h00};
    cap_q.delete();
    addr = 11'h7FF; n_ras_b = 1'b0;
    tick(2);
    for (int c = 1; c <= 3; c++) begin
      addr = 11'(c); n_cas_0 = 1'b0;
      tick(2);
      n_cas_0 = 1'b1;
      tick(2);
    end
    n_ras_b = 1'b1;
    wait_bytes(15);
    tick(3);
    checks++;
    if (cap_q.size() != 15) begin
      errors++;
      $display("FAIL page_mode_count: got %0d bytes, required 15", cap_q.size());
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (cap_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL page_mode_b%0d: got %h, required %h", i, cap_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_cbr();
    cap_q.delete();
    addr = 11'h010; n_cas_0 = 1'b0;
    tick(2);
    n_ras_a = 1'b0;
    tick(3);
    n_ras_a = 1'b1; n_cas_0 = 1'b1;
    tick(12);
    checks++;
    if (cap_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL cbr: got %0d bytes valid=%b, required 0 bytes valid=0", cap_q.size(), out_valid);
    end
  endtask

  task automatic test_trace_en();
    cap_q.delete();
    trace_en = 1'b0;
    bus_access(0, 0, 11'h0AB, 2'b01, 11'h0CD, 0, 0, 8'h00);
    tick(8);
    trace_en = 1'b1;
    checks++;
    if (cap_q.size() != 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL trace_en_off: got %0d bytes ovf=%b, required 0 bytes ovf=0", cap_q.size(), overflow);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [15] = '{8'hCB, 8'hA5, 8'hC3, 8'hD0, 8'h5A,
                             8'h48, 8'h01, 8'hFF, 8'hF8, 8'h00,
                             8'h8C, 8'h00, 8'h12, 8'h08, 8'h00};
    bit done = 1'b0;
    bit stalled = 1'b0;
    logic [7:0] held = '0;
    cap_q.delete();
    fork
      begin
        bus_access(1, 0, 11'h3A5, 2'b10, 11'h6C3, 1, 1, 8'h5A);
        bus_access(0, 0, 11'h001, 2'b11, 11'h7FF, 1, 0, 8'h33);
        bus_access(1, 0, 11'h400, 2'b01, 11'h012, 0, 1, 8'h77);
        wait_bytes(15);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
              errors++;
              $display("FAIL stall_hold: valid=%b data=%h, required 1 %h", out_valid, out_data, held);
            end
          end
          stalled = out_valid && !out_ready;
          held = out_data;
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    tick(3);
    checks++;
    if (cap_q.size() != 15) begin
      errors++;
      $display("FAIL backpressure_count: got %0d bytes, required 15", cap_q.size());
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (cap_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL backpressure_b%0d: got %h, required %h", i, cap_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_filter();
    logic [7:0] exp [10] = '{8'h09, 8'h23, 8'h45, 8'h08, 8'h00,
                             8'h0A, 8'h23, 8'h45, 8'h08, 8'h00};
    int n;
`ifdef BUS_MON_TRACER_FILTER_EN
    n = 5;
`else
    n = 10;
`endif
    cap_q.delete();
    filter_mask = 11'h700; filter_match = 11'h100;
    bus_access(0, 0, 11'h123, 2'b01, 11'h045, 0, 0, 8'h00);
    bus_access(0, 0, 11'h223, 2'b01, 11'h045, 0, 0, 8'h00);
    wait_bytes(n);
    tick(10);
    checks++;
    if (cap_q.size() != n || overflow !== 1'b0) begin
      errors++;
      $display("FAIL filter_count: got %0d bytes ovf=%b, required %0d ovf=0", cap_q.size(), overflow, n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (cap_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL filter_b%0d: got %h, required %h", i, cap_q[i], exp[i]);
      end
    end
    filter_mask = '0; filter_match = '0;
  endtask

  // One record waits in the serializer, sixteen in the FIFO, the eighteenth drops.
  task automatic test_overflow();
    logic [7:0] exp[$];
    cap_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++)
      bus_access(0, 0, 11'(k + 1), 2'b01, 11'(k), 0, 0, 8'h00);
    tick(4);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_early: got %b after 17 records, required 0", overflow);
    end
    bus_access(0, 0, 11'd18, 2'b01, 11'd17, 0, 0, 8'h00);
    tick(4);
    checks++;
    if (overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h08) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b valid=%b data=%h, required 1 1 08", overflow, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick(12);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b, required 1", overflow);
    end
    bus_access(0, 0, 11'h055, 2'b01, 11'h0AA, 0, 0, 8'h00);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %b, required 0", overflow);
    end
    for (int k = 0; k < 17; k++) begin
      exp.push_back(8'h08); exp.push_back(8'(k + 1)); exp.push_back(8'(k));
      exp.push_back(8'h08); exp.push_back(8'h00);
    end
    exp.push_back(8'h18); exp.push_back(8'h55); exp.push_back(8'hAA);
    exp.push_back(8'h08); exp.push_back(8'h00);
    wait_bytes(90);
    tick(3);
    checks++;
    if (cap_q.size() != 90) begin
      errors++;
      $display("FAIL overflow_count: got %0d bytes, required 90", cap_q.size());
    end
    for (int i = 0; i < 90; i++) begin
      checks++;
      if (cap_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL overflow_b%0d: got %h, required %h", i, cap_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_record();
    cap_q.delete();
    out_ready = 1'b0;
    bus_access(0, 1, 11'h321, 2'b10, 11'h00F, 1, 1, 8'h3C);
    bus_access(0, 0, 11'h111, 2'b01, 11'h00E, 0, 0, 8'h00);
    tick(3);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_record_setup: valid=%b, required 1", out_valid);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h ovf=%b, required 0 00 0", out_valid, out_data, overflow);
    end
    tick(2);
    n_rst = 1'b1;
    out_ready = 1'b1;
    tick(20);
    checks++;
    if (cap_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got %0d bytes valid=%b, required 0 bytes valid=0", cap_q.size(), out_valid);
    end
  endtask

  initial begin
    n_rst = 1'b0; trace_en = 1'b1; out_ready = 1'b1;
    n_ras_a = 1'b1; n_ras_b = 1'b1; n_cas_0 = 1'b1; n_cas_1 = 1'b1; n_nren = 1'b1;
    n_we = 1'b1; data_out_en = 1'b0; addr = '0; data_out = '0;
    filter_match = '0; filter_mask = '0;
    tick(3);
    test_reset();
    n_rst = 1'b1;
    tick(2);
    test_single_write();
    test_page_mode();
    test_cbr();
    test_trace_en();
    test_backpressure();
    test_filter();
    test_overflow();
    test_reset_mid_record();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
